sram_port_ctrl: RTL and testbench
=================================

# sram_port_ctrl

Single-port controller between a request/grant bus master (core LSU, debug, or interconnect port) and one single-port SRAM wrapper with active-low chip select, write enable and byte enables, and read data valid one cycle after the access. After reset it fills the whole array with a constant value. It then serves bus requests with one-cycle grant/rvalid timing, and it holds read data stable on the bus between responses.

## Interface
- ADDR_WIDTH, 12: word-address width; array depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; multiple of 8; BE_WIDTH = DATA_WIDTH/8.
- INIT_ON_RESET, 1: 1 = run init fill after reset; 0 = go straight to READY.
- INIT_VALUE, 0: DATA_WIDTH-bit fill value.

Ports:
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_i  in  1  bus request.
- gnt_o  out  1  grant; access is accepted in the cycle where req_i && gnt_o.
- addr_i  in  ADDR_WIDTH  word address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  BE_WIDTH  byte enables, active-high.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response valid, asserted for reads and writes.
- rdata_o  out  DATA_WIDTH  read data.
- init_done_o  out  1  high once the controller is in READY.
- CSN  out  1  SRAM chip select, active-low.
- WEN  out  1  SRAM write enable, active-low.
- A  out  ADDR_WIDTH  SRAM address.
- D  out  DATA_WIDTH  SRAM write data.
- BEN  out  BE_WIDTH  SRAM byte write enables, active-low.
- Q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read access.

## Operation
- FSM states:
  - INIT: fill cycles. One SRAM write per cycle: CSN=0, WEN=0, BEN=0, A=init_cnt, D=INIT_VALUE. gnt_o=0. init_cnt increments each cycle. When init_cnt = 2^ADDR_WIDTH-1 (wrap point), the next state is READY.
  - READY: serves bus requests. The SRAM interface is driven combinationally from the bus:
    - CSN = ~req_i, WEN = ~we_i, A = addr_i, D = wdata_i, BEN = ~be_i; gnt_o = 1.
    - With req_i=0: CSN=1, and WEN/BEN are all ones.
    - A write with be_i=0 is still granted and still gets rvalid; no byte is changed.
- Exit from reset: INIT if INIT_ON_RESET=1, else READY. READY is terminal until the next RST.
- Response: a registered pending flag, rd_pend, records that the access granted in the previous cycle was a read.
  - rvalid_o is a register set to 1 in the cycle after any grant.
  - Read response: when rvalid_o=1 and rd_pend=1, rdata_o = Q, and Q is captured into hold_q at the end of that cycle.
  - Otherwise rdata_o = hold_q. Write responses and idle cycles do not disturb rdata_o.
- Back-to-back accesses are accepted every cycle; the controller has no backpressure in READY.
- RST high at any time:
  - FSM goes to INIT (or READY if INIT_ON_RESET=0), init_cnt=0, rvalid_o=0, rd_pend=0, hold_q=0.
  - A pending response is dropped, and a fill in progress restarts from address 0.
- Reset values while RST=1: gnt_o=0, rvalid_o=0, rdata_o=0, init_done_o=0, CSN=1, WEN=1, BEN=all ones, A=0, D=0. The SRAM is never accessed during reset.

## Timing
- Init fill:
  - The first fill write is in the first cycle with RST=0.
  - The fill takes exactly 2^ADDR_WIDTH cycles.
  - init_done_o and gnt_o rise in cycle 2^ADDR_WIDTH after reset release, counting the first post-reset cycle as cycle 0.
- Access latency: request granted in cycle T; rvalid_o=1 and read data on rdata_o in cycle T+1.
- Throughput: 1 access per cycle.
- Combinational paths: req_i/addr_i/we_i/be_i/wdata_i to CSN/WEN/A/D/BEN; Q to rdata_o.
- The only registered outputs are rvalid_o, the state bit driving init_done_o, and hold_q.
- Requests with req_i=1 during INIT are not granted; the master holds them until gnt_o=1.

## Test plan
- Reset release, ADDR_WIDTH=4, INIT_VALUE=32'hA5A5A5A5 -> 16 consecutive writes to addresses 0..15 with BEN=4'b0000; init_done_o and gnt_o rise in cycle 16; then reads of addresses 0, 7 and 15 return A5A5A5A5 one cycle after grant.
- Write 32'h11223344 to address 3 with be=4'b0101, then read address 3 -> rdata_o=32'hA522A544; rvalid_o=1 for exactly the cycle after each grant.
- Back-to-back: read address 1, write address 2, read address 2, then idle -> rvalid_o high for 3 consecutive cycles. rdata_o stays at the address 1 data during the write response, shows the new address 2 data on the third response, and holds that value during idle cycles.
- RST pulsed when init_cnt=9 -> CSN=1 during RST; the fill restarts at address 0 and completes 16 cycles after release; init_done_o stays 0 throughout.
- RST pulsed in the cycle after a read grant -> rvalid_o=0 and rdata_o=0 in the following cycle; no stale response appears.
- INIT_ON_RESET=0 -> gnt_o=1 and init_done_o=1 in the first cycle after release; CSN stays 1 while req_i=0.

Source files
------------

// File: rtl/sram_port_ctrl_if.sv
// Request/grant bus between a master (LSU, debug, interconnect) and the SRAM port controller.
interface sram_port_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_i;
    logic                  gnt_o;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;

    modport master (output req_i, addr_i, we_i, be_i, wdata_i,
                    input  gnt_o, rvalid_o, rdata_o);
    modport slave  (input  req_i, addr_i, we_i, be_i, wdata_i,
                    output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/sram_port_ctrl.sv
// Single-port SRAM controller: post-reset fill of the whole array, then one-cycle
// grant/rvalid bus service with read data held stable between responses.
module sram_port_ctrl #(
    parameter int                  ADDR_WIDTH    = 12,
    parameter int                  DATA_WIDTH    = 32,
    parameter bit                  INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    sram_port_ctrl_if.slave         bus,
    output logic                    init_done_o,
    output logic                    CSN,
    output logic                    WEN,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic [DATA_WIDTH-1:0]   D,
    output logic [DATA_WIDTH/8-1:0] BEN,
    input  logic [DATA_WIDTH-1:0]   Q
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {S_INIT, S_READY} state_t;
    localparam state_t RESET_STATE = INIT_ON_RESET ? S_INIT : S_READY;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rvalid_q, rd_pend_q;
    logic [DATA_WIDTH-1:0] hold_q;

    logic                  gnt, acc;
    logic                  csn, wen;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic [BE_WIDTH-1:0]   ben;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= acc;
            rd_pend_q <= acc & ~bus.we_i;
            if (rvalid_q && rd_pend_q)
                hold_q <= Q;
        end
    end

    // SRAM stays idle while RST is high, whatever the bus is doing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        acc     = 1'b0;
        csn     = 1'b1;
        wen     = 1'b1;
        ben     = '1;
        a       = '0;
        d       = '0;
        if (!RST) begin
            unique case (state_q)
                S_INIT: begin
                    csn   = 1'b0;
                    wen   = 1'b0;
                    ben   = '0;
                    a     = cnt_q;
                    d     = INIT_VALUE;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1)
                        state_d = S_READY;
                end
                S_READY: begin
                    gnt = 1'b1;
                    acc = bus.req_i;
                    csn = ~bus.req_i;
                    a   = bus.addr_i;
                    d   = bus.wdata_i;
                    if (bus.req_i) begin
                        wen = ~bus.we_i;
                        ben = ~bus.be_i;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    assign CSN = csn;
    assign WEN = wen;
    assign A   = a;
    assign D   = d;
    assign BEN = ben;

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid_q & ~RST;
    assign bus.rdata_o  = RST                    ? '0 :
                          (rvalid_q && rd_pend_q) ? Q  : hold_q;
    assign init_done_o  = (state_q == S_READY) & ~RST;
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench with response scoreboard; u0 runs the 16-word fill, u1 starts ready.
module tb_sram_port_ctrl;
    localparam int          AW = 4;
    localparam int          DW = 32;
    localparam int          BW = 4;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    sram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    logic          csn0, wen0, done0, csn1, wen1, done1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, q0, q1;
    logic [BW-1:0] ben0, ben1;
    logic [DW-1:0] mem0 [16];
    logic [DW-1:0] mem1 [16];

    sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)) u0 (
        .CLK(clk), .RST(rst), .bus(bus0.slave), .init_done_o(done0),
        .CSN(csn0), .WEN(wen0), .A(a0), .D(d0), .BEN(ben0), .Q(q0));

    sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1'b0), .INIT_VALUE(IV)) u1 (
        .CLK(clk), .RST(rst), .bus(bus1.slave), .init_done_o(done1),
        .CSN(csn1), .WEN(wen1), .A(a1), .D(d1), .BEN(ben1), .Q(q1));

    // SRAM models: byte-masked write, read data one cycle after the access.
    always @(posedge clk) begin
        if (!csn0) begin
            if (!wen0) begin
                for (int b = 0; b < BW; b++)
                    if (!ben0[b]) mem0[a0][8*b +: 8] <= d0[8*b +: 8];
            end else q0 <= mem0[a0];
        end
    end

    always @(posedge clk) begin
        if (!csn1) begin
            if (!wen1) begin
                for (int b = 0; b < BW; b++)
                    if (!ben1[b]) mem1[a1][8*b +: 8] <= d1[8*b +: 8];
            end else q1 <= mem1[a1];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] hold_exp = '0;
    logic        prev_acc = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            prev_acc <= 1'b0;
            hold_exp <= '0;
            exp_q.delete();
        end else begin
            chk("rvalid_after_grant", 32'(bus0.rvalid_o), 32'(prev_acc));
            if (bus0.rvalid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rvalid=1 with no outstanding access, expected rvalid=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", bus0.rdata_o, e);
                    hold_exp <= e;
                end
            end else begin
                chk("rdata_hold", bus0.rdata_o, hold_exp);
            end
            prev_acc <= bus0.req_i && bus0.gnt_o;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic access(input logic w, input logic [AW-1:0] ad, input logic [BW-1:0] b,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp);
        int n;
        n = 0;
        bus0.req_i = 1'b1; bus0.we_i = w; bus0.addr_i = ad; bus0.be_i = b; bus0.wdata_i = wd;
        @(negedge clk);
        while (!bus0.gnt_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_latency", 32'(n), 32'd0);
        if (bus0.gnt_o) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus0.req_i = 1'b0;
    endtask

    task automatic fill_check(input int n, input bit first);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("fill_csn", 32'(csn0), 32'd0);
            chk("fill_wen", 32'(wen0), 32'd0);
            chk("fill_ben", 32'(ben0), 32'd0);
            chk("fill_addr", 32'(a0), 32'(k));
            chk("fill_data", d0, IV);
            chk("fill_gnt", 32'(bus0.gnt_o), 32'd0);
            chk("fill_done", 32'(done0), 32'd0);
            if (first && k == 0) begin
                chk("noinit_gnt", 32'(bus1.gnt_o), 32'd1);
                chk("noinit_done", 32'(done1), 32'd1);
                chk("noinit_csn", 32'(csn1), 32'd1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic ready_edge();
        @(negedge clk);
        chk("done_rise", 32'(done0), 32'd1);
        chk("gnt_rise", 32'(bus0.gnt_o), 32'd1);
        if (bus0.req_i && bus0.gnt_o) exp_q.push_back(IV);
        @(posedge clk); #1;
        bus0.req_i = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = '0; bus0.be_i = '0; bus0.wdata_i = '0;
        bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = '0; bus1.be_i = '0; bus1.wdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(bus0.gnt_o), 32'd0);
        chk("rst_rvalid", 32'(bus0.rvalid_o), 32'd0);
        chk("rst_rdata", bus0.rdata_o, 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_csn", 32'(csn0), 32'd1);
        chk("rst_wen", 32'(wen0), 32'd1);
        chk("rst_ben", 32'(ben0), 32'hF);
        chk("rst_a", 32'(a0), 32'd0);
        chk("rst_d", d0, 32'd0);
        chk("rst_gnt_u1", 32'(bus1.gnt_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Master holds a read of address 0 throughout the fill.
        bus0.req_i = 1'b1; bus0.we_i = 1'b0; bus0.addr_i = '0;
        fill_check(16, 1'b1);
        ready_edge();

        access(1'b0, 4'd7, 4'h0, 32'h0, IV);
        access(1'b0, 4'd15, 4'h0, 32'h0, IV);
        idle(1);
        access(1'b1, 4'd3, 4'b0101, 32'h11223344, IV);
        idle(1);
        access(1'b0, 4'd3, 4'h0, 32'h0, 32'hA522A544);
        idle(1);
        access(1'b1, 4'd4, 4'b0000, 32'hFFFFFFFF, 32'hA522A544);
        access(1'b0, 4'd4, 4'h0, 32'h0, IV);
        idle(1);
        access(1'b0, 4'd1, 4'h0, 32'h0, IV);
        access(1'b1, 4'd2, 4'hF, 32'hCAFEF00D, IV);
        access(1'b0, 4'd2, 4'h0, 32'h0, 32'hCAFEF00D);
        idle(3);

        bus1.req_i = 1'b1; bus1.we_i = 1'b1; bus1.addr_i = 4'd5; bus1.be_i = 4'hF; bus1.wdata_i = 32'h12345678;
        @(negedge clk);
        chk("u1_wr_gnt", 32'(bus1.gnt_o), 32'd1);
        chk("u1_wr_csn", 32'(csn1), 32'd0);
        chk("u1_wr_wen", 32'(wen1), 32'd0);
        chk("u1_wr_ben", 32'(ben1), 32'd0);
        chk("u1_wr_a", 32'(a1), 32'd5);
        @(posedge clk); #1;
        bus1.we_i = 1'b0;
        @(negedge clk);
        chk("u1_wr_rvalid", 32'(bus1.rvalid_o), 32'd1);
        chk("u1_rd_wen", 32'(wen1), 32'd1);
        @(posedge clk); #1;
        bus1.req_i = 1'b0;
        @(negedge clk);
        chk("u1_rd_rvalid", 32'(bus1.rvalid_o), 32'd1);
        chk("u1_rd_rdata", bus1.rdata_o, 32'h12345678);
        @(posedge clk); #1;
        @(negedge clk);
        chk("u1_idle_rvalid", 32'(bus1.rvalid_o), 32'd0);
        chk("u1_idle_rdata", bus1.rdata_o, 32'h12345678);
        chk("u1_idle_csn", 32'(csn1), 32'd1);
        @(posedge clk); #1;

        // Reset lands in the response cycle of a read: response must vanish.
        access(1'b0, 4'd0, 4'h0, 32'h0, IV);
        rst = 1'b1;
        @(negedge clk);
        chk("rstrsp_rvalid", 32'(bus0.rvalid_o), 32'd0);
        chk("rstrsp_rdata", bus0.rdata_o, 32'd0);
        chk("rstrsp_csn", 32'(csn0), 32'd1);
        chk("rstrsp_gnt", 32'(bus0.gnt_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fill_check(9, 1'b0);

        // Reset while init_cnt = 9; fill must restart from address 0.
        rst = 1'b1;
        @(negedge clk);
        chk("midfill_csn", 32'(csn0), 32'd1);
        chk("midfill_a", 32'(a0), 32'd0);
        chk("midfill_done", 32'(done0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fill_check(16, 1'b0);
        ready_edge();
        access(1'b0, 4'd3, 4'h0, 32'h0, IV);
        access(1'b0, 4'd2, 4'h0, 32'h0, IV);
        idle(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
